// File: rtl/three_input_debounce_sync_pkg.sv
// Shared constants for the three-channel input synchronizer/debouncer.
// Channel indices map bit positions of the packed channel vectors.
package three_input_debounce_sync_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT         = 3;

    localparam int NUM_CH = 3;
    localparam int CH_A   = 0;
    localparam int CH_B   = 1;
    localparam int CH_C   = 2;

endpackage

// File: rtl/three_input_debounce_sync_debounce_channel.sv
// One input channel: two-flop synchronizer followed by a stability-counter debouncer.
// Optional macro EDGE_PULSE_EN adds a registered one-cycle pulse on each 0->1 of q.
module debounce_channel
    import three_input_debounce_sync_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q
`ifdef EDGE_PULSE_EN
    ,
    output logic rise
`endif
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // raw is asynchronous; only sync2 is allowed to reach the debounce logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any return of sync2 to q clears the count, so separate glitches never add up.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            q     <= 1'b0;
        end else if (sync2 == q) begin
            count <= '0;
        end else if (count == CNT_W'(STABLE_CYCLES - 1)) begin
            q     <= sync2;
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

`ifdef EDGE_PULSE_EN
    logic q_prev;

    // Pulse lands on the cycle after q has risen.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_prev <= 1'b0;
            rise   <= 1'b0;
        end else begin
            q_prev <= q;
            rise   <= q & ~q_prev;
        end
    end
`endif

endmodule

// File: rtl/three_input_debounce_sync.sv
// Conditions three raw board inputs into clean, clock-aligned a/b/c for the OR gate.
// Optional macro EDGE_PULSE_EN adds the 3-bit rise output (bit0=a, bit1=b, bit2=c).
module three_input_debounce_sync
    import three_input_debounce_sync_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    input  logic       c_raw,
    output logic       a,
    output logic       b,
    output logic       c
`ifdef EDGE_PULSE_EN
    ,
    output logic [2:0] rise
`endif
);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] q_vec;

    always_comb begin
        raw_vec       = '0;
        raw_vec[CH_A] = a_raw;
        raw_vec[CH_B] = b_raw;
        raw_vec[CH_C] = c_raw;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[i]),
            .q    (q_vec[i])
`ifdef EDGE_PULSE_EN
            ,
            .rise (rise[i])
`endif
        );
    end

    assign a = q_vec[CH_A];
    assign b = q_vec[CH_B];
    assign c = q_vec[CH_C];

endmodule

// File: tb/tb_three_input_debounce_sync.sv
// Scenario bench for three_input_debounce_sync: expected {c,b,a} words are queued as
// stimulus is driven and popped one per clock as the outputs are sampled.
module tb_three_input_debounce_sync;
    import three_input_debounce_sync_pkg::*;

    localparam int SC  = STABLE_CYCLES_DEFAULT;
    localparam int LAT = SC + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic c_raw = 1'b0;
    logic a, b, c;
    logic a1, b1, c1;
`ifdef EDGE_PULSE_EN
    logic [2:0] rise;
    logic [2:0] rise1;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [2:0] exp_q[$];
    logic [2:0] rise_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    three_input_debounce_sync dut (
        .clk  (clk),
        .reset(reset),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .c_raw(c_raw),
        .a    (a),
        .b    (b),
        .c    (c)
`ifdef EDGE_PULSE_EN
        ,
        .rise (rise)
`endif
    );

    three_input_debounce_sync #(.STABLE_CYCLES(1), .CNT_W(1)) dut1 (
        .clk  (clk),
        .reset(reset),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .c_raw(c_raw),
        .a    (a1),
        .b    (b1),
        .c    (c1)
`ifdef EDGE_PULSE_EN
        ,
        .rise (rise1)
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic drive_raw(input logic [2:0] v);
        {c_raw, b_raw, a_raw} = v;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic clean_reset(input logic [2:0] v);
        @(negedge clk);
        drive_raw(v);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2:0] got, exp;
        @(negedge clk);
        drive_raw(3'b111);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(3'b000);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL reset_hold cycle %0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
`ifdef EDGE_PULSE_EN
            chk_cnt++;
            if (rise !== 3'b000) $display("FAIL reset_rise cycle %0d: got %b expected 000", i, rise);
            else pass_cnt++;
`endif
        end
        reset = 1'b0;
        for (int i = 0; i < LAT; i++) exp_q.push_back(3'b000);
        for (int i = 0; i < 3; i++) exp_q.push_back(3'b111);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL reset_release edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_all_fall();
        logic [2:0] got, exp;
        drive_raw(3'b000);
        for (int i = 0; i < LAT; i++) exp_q.push_back(3'b111);
        for (int i = 0; i < 3; i++) exp_q.push_back(3'b000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL all_fall edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_step_a();
        logic [2:0] got, exp;
        clean_reset(3'b000);
        idle(2);
        drive_raw(3'b001);
        for (int i = 0; i < LAT; i++) exp_q.push_back(3'b000);
        for (int i = 0; i < 3; i++) exp_q.push_back(3'b001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL step_a edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch_a();
        logic [2:0] got, exp;
        clean_reset(3'b000);
        idle(2);
        for (int i = 0; i < 14; i++) begin
            drive_raw({2'b00, 1'((i < SC - 1) || (i >= SC && i < 2 * SC - 1))});
            exp_q.push_back(3'b000);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL glitch_a cycle %0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_random_glitches();
        logic [2:0] got, exp, m;
        int len, gap;
        clean_reset(3'b000);
        idle(2);
        for (int it = 0; it < 12; it++) begin
            m   = 3'($urandom_range(1, 7));
            len = $urandom_range(1, SC - 1);
            gap = $urandom_range(1, 3);
            for (int j = 0; j < len + gap; j++) begin
                drive_raw((j < len) ? m : 3'b000);
                exp_q.push_back(3'b000);
                @(negedge clk);
                exp = exp_q.pop_front();
                got = {c, b, a};
                chk_cnt++;
                if (got !== exp) $display("FAIL random_glitch it %0d cycle %0d mask %b: got %b expected %b", it, j, m, got, exp);
                else pass_cnt++;
            end
        end
        // Let the last glitch drain through the synchronizer before moving on.
        for (int j = 0; j < LAT; j++) begin
            exp_q.push_back(3'b000);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL random_glitch tail %0d: got %b expected %b", j, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_count();
        logic [2:0] got, exp;
        clean_reset(3'b000);
        idle(2);
        drive_raw(3'b010);
        // Edges k..k+3 bring count to 2; reset lands on edge k+4 and k+5.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) reset = 1'b1;
            exp_q.push_back(3'b000);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL mid_count_pre cycle %0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
        reset = 1'b0;
        for (int i = 0; i < LAT; i++) exp_q.push_back(3'b000);
        for (int i = 0; i < 3; i++) exp_q.push_back(3'b010);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL mid_count_post edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_edge_pulse_c();
        logic [2:0] got, exp, rexp;
        clean_reset(3'b000);
        idle(2);
        drive_raw(3'b100);
        for (int i = 0; i < LAT + 4; i++) begin
            exp_q.push_back((i >= LAT) ? 3'b100 : 3'b000);
            rise_q.push_back((i == LAT + 1) ? 3'b100 : 3'b000);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            exp  = exp_q.pop_front();
            rexp = rise_q.pop_front();
            got  = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL c_rise edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
`ifdef EDGE_PULSE_EN
            chk_cnt++;
            if (rise !== rexp) $display("FAIL rise_pulse edge k+%0d: got %b expected %b", i, rise, rexp);
            else pass_cnt++;
`endif
        end
        drive_raw(3'b000);
        for (int i = 0; i < LAT + 4; i++) begin
            exp_q.push_back((i >= LAT) ? 3'b000 : 3'b100);
            rise_q.push_back(3'b000);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            exp  = exp_q.pop_front();
            rexp = rise_q.pop_front();
            got  = {c, b, a};
            chk_cnt++;
            if (got !== exp) $display("FAIL c_fall edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
`ifdef EDGE_PULSE_EN
            chk_cnt++;
            if (rise !== rexp) $display("FAIL fall_no_pulse edge k+%0d: got %b expected %b", i, rise, rexp);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_stable_one();
        logic [2:0] got, exp;
        clean_reset(3'b000);
        idle(2);
        // One-cycle raw pulse passes unfiltered, delayed by two edges.
        drive_raw(3'b001);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (i == 0) drive_raw(3'b000);
            exp = exp_q.pop_front();
            got = {c1, b1, a1};
            chk_cnt++;
            if (got !== exp) $display("FAIL sc1_pulse edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
        drive_raw(3'b110);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b110);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {c1, b1, a1};
            chk_cnt++;
            if (got !== exp) $display("FAIL sc1_step edge k+%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_all_fall();
        test_step_a();
        test_glitch_a();
        test_random_glitches();
        test_reset_mid_count();
        test_edge_pulse_c();
        test_stable_one();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
